// File: rtl/int_pc_trigger.sv
// int_pc_trigger: PC-triggered multi-channel external interrupt source.
// A small ordered table of (word PC, channel, last) entries is walked one
// entry at a time; when the CPU's committed PC reaches the current entry the
// entry's channel line is raised, and the CPU drops it again by storing to
// that channel's acknowledge word. Lines left unacknowledged for too long
// raise a sticky per-channel error flag.
module int_pc_trigger #(
  parameter int          NUM_CH     = 4,
  parameter int          DEPTH      = 16,
  parameter logic [31:0] ACK_BASE   = 32'h0000_7f20,
  parameter int          ACK_STRIDE = 4,
  parameter int          TIMEOUT    = 1024,
  parameter int          CW         = 16,
  localparam int         IW         = $clog2(DEPTH),
  localparam int         CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [31:0]       cfg_pc,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic              cfg_last,
  input  logic [31:0]       macroscopic_pc,
  input  logic [31:0]       m_int_addr,
  input  logic [3:0]        m_int_byteen,
  output logic [NUM_CH-1:0] interrupt,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     fired_cnt,
  output logic [NUM_CH-1:0] ack_err
);

  localparam int             TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO       = TW'(TIMEOUT);
  localparam logic [IW-1:0]  PTR_LAST  = IW'(DEPTH - 1);
  localparam logic [CHW:0]   NUM_CH_W  = (CHW + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] int_q, int_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TW-1:0]     timer_q [NUM_CH];
  logic [TW-1:0]     timer_d [NUM_CH];

  // Trigger table storage; contents are only meaningful once written.
  logic [29:0]       tbl_pc_q   [DEPTH];
  logic [CHW-1:0]    tbl_ch_q   [DEPTH];
  logic              tbl_last_q [DEPTH];

  logic              cfg_ok;
  logic [29:0]       cur_pc;
  logic [CHW-1:0]    cur_ch;
  logic              cur_last;
  logic              ch_in_range;
  logic              cur_line;
  logic              pc_match;
  logic              fire;
  logic [NUM_CH-1:0] ack_hit;
  logic              unused_ok;

  // The word-offset bits of the incoming addresses carry no information here.
  assign unused_ok = ^{cfg_pc[1:0], macroscopic_pc[1:0], m_int_addr[1:0]};

  // Table edits are only accepted while no sequence is running.
  assign cfg_ok = cfg_we && (state_q != ARMED);

  // Table write port; no reset so the storage can map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tbl_pc_q[cfg_idx]   <= cfg_pc[31:2];
      tbl_ch_q[cfg_idx]   <= cfg_ch;
      tbl_last_q[cfg_idx] <= cfg_last;
    end
  end

  assign cur_pc   = tbl_pc_q[ptr_q];
  assign cur_ch   = tbl_ch_q[ptr_q];
  assign cur_last = tbl_last_q[ptr_q];

  // Current entry match; an entry naming a non-existent channel never fires,
  // and a channel whose line is still up blocks its entry until acknowledged.
  always_comb begin
    ch_in_range = ({1'b0, cur_ch} < NUM_CH_W);
    cur_line    = 1'b1;
    if (ch_in_range) begin
      cur_line = int_q[cur_ch];
    end
    pc_match = (macroscopic_pc[31:2] == cur_pc);
    fire     = (state_q == ARMED) && !start && pc_match && ch_in_range && !cur_line;
  end

  // Decode acknowledge stores: any byte lane written to a channel's ack word.
  always_comb begin
    ack_hit = '0;
    if (|m_int_byteen) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ({m_int_addr[31:2], 2'b00} == (ACK_BASE + 32'(k * ACK_STRIDE))) begin
          ack_hit[k] = 1'b1;
        end
      end
    end
  end

  // Sequencer next-state: start (re)arms from entry 0, fires advance the pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (start) begin
          ptr_d = '0;
          cnt_d = '0;
        end else if (fire) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cur_last || (ptr_q == PTR_LAST)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d = ARMED;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == ARMED);
    done_d = (state_d == DONE);
  end

  // Per-channel line, ack-wait timer and sticky timeout flag; these keep
  // running in every state so earlier lines can still be acknowledged.
  always_comb begin
    int_d = int_q;
    err_d = start ? '0 : err_q;
    for (int k = 0; k < NUM_CH; k++) begin
      timer_d[k] = timer_q[k];
      if (int_q[k] && (timer_q[k] != TMO)) begin
        timer_d[k] = timer_q[k] + 1'b1;
        if (timer_q[k] == TMO - 1'b1) begin
          err_d[k] = 1'b1;
        end
      end
      if (ack_hit[k] && int_q[k]) begin
        int_d[k] = 1'b0;
      end
      if (fire && (cur_ch == CHW'(k))) begin
        int_d[k]   = 1'b1;
        timer_d[k] = '0;
      end
    end
  end

  // State and channel registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      int_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        timer_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      int_q   <= int_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int k = 0; k < NUM_CH; k++) begin
        timer_q[k] <= timer_d[k];
      end
    end
  end

  assign interrupt = int_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fired_cnt = cnt_q;
  assign ack_err   = err_q;

endmodule

// File: tb/tb_int_pc_trigger.sv
// Directed bench for int_pc_trigger with a short timeout so the ack-error
// path can be reached quickly.
module tb_int_pc_trigger;

  localparam int NUM_CH  = 4;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int CW      = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_idx = '0;
  logic [31:0]       cfg_pc = '0;
  logic [1:0]        cfg_ch = '0;
  logic              cfg_last = 1'b0;
  logic [31:0]       macroscopic_pc = '0;
  logic [31:0]       m_int_addr = '0;
  logic [3:0]        m_int_byteen = '0;
  logic [NUM_CH-1:0] interrupt;
  logic              busy;
  logic              done;
  logic [CW-1:0]     fired_cnt;
  logic [NUM_CH-1:0] ack_err;

  int assertCount = 0;
  int failCount   = 0;

  int_pc_trigger #(
    .NUM_CH    (NUM_CH),
    .DEPTH     (DEPTH),
    .ACK_BASE  (32'h0000_7f20),
    .ACK_STRIDE(4),
    .TIMEOUT   (TIMEOUT),
    .CW        (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_pc        (cfg_pc),
    .cfg_ch        (cfg_ch),
    .cfg_last      (cfg_last),
    .macroscopic_pc(macroscopic_pc),
    .m_int_addr    (m_int_addr),
    .m_int_byteen  (m_int_byteen),
    .interrupt     (interrupt),
    .busy          (busy),
    .done          (done),
    .fired_cnt     (fired_cnt),
    .ack_err       (ack_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyEntry(input int idx, input logic [31:0] pc, input int ch, input logic last);
    cfg_we   = 1'b1;
    cfg_idx  = 4'(idx);
    cfg_pc   = pc;
    cfg_ch   = 2'(ch);
    cfg_last = last;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic applyStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStore(input logic [31:0] addr, input logic [3:0] be);
    m_int_addr   = addr;
    m_int_byteen = be;
    tick();
    m_int_byteen = 4'b0000;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    checkOutput("rst_int", 32'(interrupt), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_cnt", 32'(fired_cnt), 32'h0);
    checkOutput("rst_err", 32'(ack_err), 32'h0);
    reset = 1'b1;
    tick();

    // Single last entry on channel 0; PC low bits are ignored
    $display("[TB] single-entry sequence");
    applyEntry(0, 32'h3010, 0, 1'b1);
    applyStart();
    checkOutput("t1_busy", 32'(busy), 32'h1);
    macroscopic_pc = 32'h300c;
    tick();
    checkOutput("t1_nomatch", 32'(interrupt), 32'h0);
    macroscopic_pc = 32'h3012;
    tick();
    checkOutput("t1_int", 32'(interrupt), 32'h1);
    checkOutput("t1_cnt", 32'(fired_cnt), 32'h1);
    checkOutput("t1_done", 32'(done), 32'h1);
    checkOutput("t1_busy_off", 32'(busy), 32'h0);
    macroscopic_pc = 32'h0;

    // Ack decode: out-of-range channel, below window, no byte enables, then real ack
    $display("[TB] acknowledge decode");
    applyStore(32'h7f30, 4'b1111);
    checkOutput("t2_k4", 32'(interrupt), 32'h1);
    applyStore(32'h7f1c, 4'b1111);
    checkOutput("t2_below", 32'(interrupt), 32'h1);
    applyStore(32'h7f20, 4'b0000);
    checkOutput("t2_nobe", 32'(interrupt), 32'h1);
    applyStore(32'h7f22, 4'b0001);
    checkOutput("t2_ack0", 32'(interrupt), 32'h0);

    // Blocked channel: second entry on ch1 waits for the ack of the first
    $display("[TB] blocked channel");
    applyEntry(0, 32'h3014, 1, 1'b0);
    applyEntry(1, 32'h3014, 1, 1'b1);
    applyStart();
    checkOutput("t3_cnt0", 32'(fired_cnt), 32'h0);
    macroscopic_pc = 32'h3014;
    tick();
    checkOutput("t3_int1", 32'(interrupt), 32'h2);
    checkOutput("t3_cnt1", 32'(fired_cnt), 32'h1);
    tick();
    tick();
    checkOutput("t3_blk_cnt", 32'(fired_cnt), 32'h1);
    checkOutput("t3_blk_ptr", 32'(dut.ptr_q), 32'h1);
    checkOutput("t3_blk_busy", 32'(busy), 32'h1);
    applyStore(32'h7f24, 4'b0010);
    checkOutput("t3_ackclr", 32'(interrupt), 32'h0);
    checkOutput("t3_ack_cnt", 32'(fired_cnt), 32'h1);
    tick();
    checkOutput("t3_refire", 32'(interrupt), 32'h2);
    checkOutput("t3_cnt2", 32'(fired_cnt), 32'h2);
    checkOutput("t3_done", 32'(done), 32'h1);
    macroscopic_pc = 32'h0;
    applyStore(32'h7f24, 4'b1000);
    checkOutput("t3_ack1", 32'(interrupt), 32'h0);
    checkOutput("t3_noerr", 32'(ack_err), 32'h0);

    // Timeout on channel 2, cleared by start while the line stays up
    $display("[TB] ack timeout");
    applyEntry(0, 32'h3020, 2, 1'b1);
    applyStart();
    macroscopic_pc = 32'h3020;
    tick();
    checkOutput("t4_int2", 32'(interrupt), 32'h4);
    macroscopic_pc = 32'h0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checkOutput("t4_err_early", 32'(ack_err), 32'h0);
    tick();
    checkOutput("t4_err", 32'(ack_err), 32'h4);
    checkOutput("t4_line_held", 32'(interrupt), 32'h4);
    tick();
    tick();
    checkOutput("t4_err_sticky", 32'(ack_err), 32'h4);
    applyStart();
    checkOutput("t4_err_clr", 32'(ack_err), 32'h0);
    tick();
    checkOutput("t4_err_stay0", 32'(ack_err), 32'h0);
    checkOutput("t4_line_kept", 32'(interrupt), 32'h4);

    // Table writes while armed are dropped
    applyEntry(0, 32'h4000, 3, 1'b1);
    macroscopic_pc = 32'h4000;
    tick();
    checkOutput("t4_cfg_ign", 32'(interrupt), 32'h4);
    macroscopic_pc = 32'h0;
    applyStore(32'h7f28, 4'b0100);
    checkOutput("t4_ack2", 32'(interrupt), 32'h0);
    macroscopic_pc = 32'h3020;
    tick();
    checkOutput("t4_orig_fire", 32'(interrupt), 32'h4);
    checkOutput("t4_orig_cnt", 32'(fired_cnt), 32'h1);
    macroscopic_pc = 32'h0;
    applyStore(32'h7f28, 4'b1111);
    checkOutput("t4_ack2b", 32'(interrupt), 32'h0);

    // Full table walk without last bits; completion at the final entry
    $display("[TB] full table walk");
    for (int i = 0; i < DEPTH; i++) begin
      applyEntry(i, 32'h5000 + 32'(4 * i), i % 4, 1'b0);
    end
    applyStart();
    for (int i = 0; i < DEPTH; i++) begin
      macroscopic_pc = 32'h5000 + 32'(4 * i);
      tick();
      checkOutput($sformatf("t5_int_%0d", i), 32'(interrupt), 32'(1 << (i % 4)));
      checkOutput($sformatf("t5_cnt_%0d", i), 32'(fired_cnt), 32'(i + 1));
      checkOutput($sformatf("t5_done_%0d", i), 32'(done), (i == DEPTH - 1) ? 32'h1 : 32'h0);
      macroscopic_pc = 32'h0;
      applyStore(32'h7f20 + 32'(4 * (i % 4)), 4'b0001 << (i % 4));
      checkOutput($sformatf("t5_ack_%0d", i), 32'(interrupt), 32'h0);
    end
    checkOutput("t5_ptr_wrap", 32'(dut.ptr_q), 32'h0);
    checkOutput("t5_busy", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a sequence
    $display("[TB] asynchronous reset");
    applyEntry(0, 32'h6000, 1, 1'b0);
    applyEntry(1, 32'h6004, 3, 1'b0);
    applyEntry(2, 32'h6008, 0, 1'b1);
    applyStart();
    macroscopic_pc = 32'h6000;
    tick();
    macroscopic_pc = 32'h6004;
    tick();
    checkOutput("t6_int_pre", 32'(interrupt), 32'ha);
    checkOutput("t6_cnt_pre", 32'(fired_cnt), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6_int", 32'(interrupt), 32'h0);
    checkOutput("t6_busy", 32'(busy), 32'h0);
    checkOutput("t6_done", 32'(done), 32'h0);
    checkOutput("t6_cnt", 32'(fired_cnt), 32'h0);
    checkOutput("t6_err", 32'(ack_err), 32'h0);
    checkOutput("t6_state", 32'(dut.state_q), 32'h0);
    macroscopic_pc = 32'h6008;
    tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("t6_idle_nofire", 32'(interrupt), 32'h0);
    checkOutput("t6_idle_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
